// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC, instruction memory and IF/ID register with stall, redirect and HALT hold
// Optional feature: define IF_STAGE_DEBUG_EN to add the o_fetch_count port and counter.
module instruction_fetch_stage #(
    parameter int NBITS      = 32,
    parameter int IMEM_DEPTH = 256,
    localparam int AW        = $clog2(IMEM_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_hazard_detected,
    input  logic             i_flg_pc_src,
    input  logic [NBITS-1:0] i_pc_target,
    input  logic             i_imem_wr_en,
    input  logic [AW-1:0]    i_imem_wr_addr,
    input  logic [31:0]      i_imem_wr_data,
    output logic [NBITS-1:0] o_pc,
    output logic [31:0]      o_instruction,
`ifdef IF_STAGE_DEBUG_EN
    output logic [31:0]      o_fetch_count,
`endif
    output logic             o_fetch_halted
);

    localparam logic [31:0] HALT_WORD = 32'hFC000000;
    localparam logic [31:0] NOP_WORD  = 32'h00000000;

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t           r_state, w_state_next;
    logic [NBITS-1:0] r_pc, w_pc_next;
    logic [NBITS-1:0] r_ifid_pc, w_ifid_pc_next;
    logic [31:0]      r_ifid_instr, w_ifid_instr_next;
    logic [31:0]      r_imem [IMEM_DEPTH];
    logic [31:0]      w_fetch_word;
    logic [NBITS-1:0] w_pc_plus4;
    logic             w_count_inc;

    // Program memory is never cleared by reset so a loaded image survives a restart.
    always_ff @(posedge i_clk) begin
        if (i_imem_wr_en) begin
            r_imem[i_imem_wr_addr] <= i_imem_wr_data;
        end
    end

    assign w_fetch_word = r_imem[r_pc[AW+1:2]];
    assign w_pc_plus4   = r_pc + NBITS'(4);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_RUN;
            r_pc         <= '0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_WORD;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_count_inc       = 1'b0;
        if (i_en) begin
            if (i_flg_pc_src) begin
                // Redirect flushes IF/ID and cancels any wrong-path HALT.
                w_pc_next         = i_pc_target;
                w_ifid_pc_next    = '0;
                w_ifid_instr_next = NOP_WORD;
                w_state_next      = ST_RUN;
            end else if (!i_hazard_detected) begin
                w_ifid_pc_next = w_pc_plus4;
                if (r_state == ST_RUN) begin
                    w_ifid_instr_next = w_fetch_word;
                    w_count_inc       = (w_fetch_word != NOP_WORD);
                    if (w_fetch_word == HALT_WORD) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_pc_next = w_pc_plus4;
                    end
                end else begin
                    w_ifid_instr_next = NOP_WORD;
                end
            end
        end
    end

`ifdef IF_STAGE_DEBUG_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_count <= '0;
        end else if (w_count_inc) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign o_fetch_count = r_fetch_count;
`else
    logic w_count_unused;
    assign w_count_unused = w_count_inc;
`endif

    assign o_pc           = r_ifid_pc;
    assign o_instruction  = r_ifid_instr;
    assign o_fetch_halted = (r_state == ST_HOLD);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    localparam int NBITS = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam logic [31:0] HALT = 32'hFC000000;
    localparam logic [31:0] NOP  = 32'h00000000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             haz = 1'b0;
    logic             src = 1'b0;
    logic [NBITS-1:0] target = '0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [31:0]      wr_data = '0;
    logic [NBITS-1:0] o_pc;
    logic [31:0]      o_instruction;
    logic             o_fetch_halted;
`ifdef IF_STAGE_DEBUG_EN
    logic [31:0]      o_fetch_count;
`endif

    instruction_fetch_stage #(.NBITS(NBITS), .IMEM_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_hazard_detected(haz),
        .i_flg_pc_src(src), .i_pc_target(target),
        .i_imem_wr_en(wr_en), .i_imem_wr_addr(wr_addr), .i_imem_wr_data(wr_data),
        .o_pc(o_pc), .o_instruction(o_instruction),
`ifdef IF_STAGE_DEBUG_EN
        .o_fetch_count(o_fetch_count),
`endif
        .o_fetch_halted(o_fetch_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NBITS-1:0] pc;
        logic [31:0]      instr;
        logic             halted;
        logic [31:0]      count;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_mem [DEPTH];
    logic [NBITS-1:0] m_pc, m_ifid_pc;
    logic [31:0] m_instr, m_count;
    logic        m_hold;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs(input exp_t e);
        check_value("o_pc", 64'(o_pc), 64'(e.pc));
        check_value("o_instruction", 64'(o_instruction), 64'(e.instr));
        check_value("o_fetch_halted", 64'(o_fetch_halted), 64'(e.halted));
`ifdef IF_STAGE_DEBUG_EN
        check_value("o_fetch_count", 64'(o_fetch_count), 64'(e.count));
`endif
    endtask

    task automatic model_reset();
        m_pc = '0; m_ifid_pc = '0; m_instr = NOP; m_hold = 1'b0; m_count = '0;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        en = 1'b0; wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
        m_mem[addr] = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1; en = 1'b1; haz = 1'b1; src = 1'b1; target = 32'h80;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; haz = 1'b0; src = 1'b0;
        e = '{pc: '0, instr: NOP, halted: 1'b0, count: '0};
        compare_outputs(e);
    endtask

    // Drive one cycle, predict the IF/ID contents, and compare after the edge.
    task automatic step(input logic s_en, input logic s_haz, input logic s_src, input logic [NBITS-1:0] s_tgt);
        logic [31:0] word;
        exp_t e, got;
        en = s_en; haz = s_haz; src = s_src; target = s_tgt;
        word = m_mem[m_pc[AW+1:2]];
        if (s_en) begin
            if (s_src) begin
                m_pc = s_tgt; m_ifid_pc = '0; m_instr = NOP; m_hold = 1'b0;
            end else if (!s_haz) begin
                m_ifid_pc = m_pc + 32'd4;
                if (m_hold) begin
                    m_instr = NOP;
                end else begin
                    m_instr = word;
                    if (word != NOP) m_count = m_count + 32'd1;
                    if (word == HALT) m_hold = 1'b1;
                    else m_pc = m_pc + 32'd4;
                end
            end
        end
        sb_q.push_back('{pc: m_ifid_pc, instr: m_instr, halted: m_hold, count: m_count});
        @(posedge clk); #1;
        en = 1'b0; haz = 1'b0; src = 1'b0;
        got = sb_q.pop_front();
        compare_outputs(got);
    endtask

    initial begin
        int wrong_path;
        logic [31:0] cnt_before;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        model_reset();
        for (int i = 0; i < 20; i++) load_word(i, 32'h20000000 + 32'(i * 3 + 1));
        load_word(0, 32'h20010005);
        load_word(1, 32'h20020007);
        load_word(2, HALT);
        load_word(18, HALT);
        load_word(255, 32'h12345678);

        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
        check_value("halt_pc", 64'(o_pc), 64'd12);
        check_value("halt_word", 64'(o_instruction), 64'(HALT));
        check_value("halt_flag", 64'(o_fetch_halted), 64'd1);
        step(1, 0, 0, '0);
        check_value("hold_pc", 64'(o_pc), 64'd12);
        check_value("hold_nop", 64'(o_instruction), 64'(NOP));
        step(1, 0, 0, '0);

        do_reset();
        step(1, 0, 0, '0);
        check_value("restart_word", 64'(o_instruction), 64'h20010005);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
        check_value("stall_pc", 64'(o_pc), 64'd4);
        step(1, 0, 0, '0);
        check_value("resume_word", 64'(o_instruction), 64'h20020007);

        step(1, 1, 1, 32'h40);
        step(1, 0, 0, '0);
        check_value("redir_pc", 64'(o_pc), 64'h44);
        check_value("redir_word", 64'(o_instruction), 64'(m_mem[16]));
        wrong_path = 0;
        while (!o_fetch_halted && wrong_path < 8) begin
            step(1, 0, 0, '0);
            wrong_path++;
        end
        check_value("wrong_path_halt", 64'(o_fetch_halted), 64'd1);
        step(1, 0, 0, '0);
        step(1, 0, 1, 32'h10);
        check_value("halt_cleared", 64'(o_fetch_halted), 64'd0);
        step(1, 0, 0, '0);
        check_value("resume_0x10", 64'(o_pc), 64'h14);

        cnt_before = m_count;
        for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 32'h20);
        check_value("pause_pc", 64'(o_pc), 64'h14);
        check_value("pause_count", 64'(m_count), 64'(cnt_before));
        step(1, 0, 0, '0);

        step(1, 0, 1, 32'hFFFFFFFC);
        step(1, 0, 0, '0);
        check_value("wrap_pc", 64'(o_pc), 64'd0);
        check_value("wrap_word", 64'(o_instruction), 64'h12345678);
        step(1, 0, 0, '0);

        for (int i = 0; i < 40; i++) begin
            logic r_src;
            r_src = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, r_src,
                 32'($urandom_range(0, 19)) << 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
